// File: rtl/silly_meter_pkg.sv
// Shared constants and FSM state type for the rising-edge meter.
package silly_meter_pkg;

  localparam int NUM_LANES = 8;
  localparam int CNT_W_DEF = 16;
  localparam int WIN_W_DEF = 12;
  localparam int SEL_W     = $clog2(NUM_LANES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/silly_edge_lane.sv
// One lane: rising-edge detect, saturating live counter with sticky overflow,
// and the result register that holds the last completed measurement.
module silly_edge_lane #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sig,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic             i_capture,
  output logic [CNT_W-1:0] o_res,
  output logic             o_res_ovf
);

  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [CNT_W-1:0] r_res;
  logic             r_res_ovf;
  logic             w_rise;
  logic             w_sat;

  assign w_rise = i_sig & ~r_prev;
  assign w_sat  = (r_cnt == '1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev    <= 1'b0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_res     <= '0;
      r_res_ovf <= 1'b0;
    end else begin
      r_prev <= i_sig;
      if (i_clear) begin
        r_cnt <= '0;
        r_ovf <= 1'b0;
      end else if (i_enable && w_rise) begin
        if (w_sat) r_ovf <= 1'b1;
        else       r_cnt <= r_cnt + CNT_W'(1);
      end
      if (i_capture) begin
        r_res     <= r_cnt;
        r_res_ovf <= r_ovf;
      end
    end
  end

  // Bypass during capture so the readback register sees the fresh result
  // on the same edge that updates r_res.
  assign o_res     = i_capture ? r_cnt : r_res;
  assign o_res_ovf = i_capture ? r_ovf : r_res_ovf;

endmodule

// File: rtl/silly_edge_meter.sv
// Counts rising edges on each gated lane over a programmable window and
// latches per-lane results for one-lane-at-a-time readback.
module silly_edge_meter
  import silly_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] sig_in,
  input  logic                 start,
  input  logic [WIN_W-1:0]     win_len,
  input  logic [SEL_W-1:0]     lane_sel,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     count,
  output logic                 ovf
);

  state_t r_state;
  state_t w_state_nxt;
  logic [WIN_W-1:0] r_win;
  logic [WIN_W-1:0] w_win_nxt;
  logic             w_clear;
  logic             w_enable;
  logic             w_capture;

  logic [NUM_LANES-1:0][CNT_W-1:0] w_res;
  logic [NUM_LANES-1:0]            w_res_ovf;
  logic [CNT_W-1:0]                r_count;
  logic                            r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_win   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_win   <= w_win_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win;
    w_clear     = 1'b0;
    w_enable    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_win_nxt   = win_len;
          w_state_nxt = (win_len == '0) ? DONE : MEASURE;
        end
      end
      MEASURE: begin
        w_enable  = 1'b1;
        w_win_nxt = r_win - WIN_W'(1);
        // The cycle with one remaining is still counted before leaving.
        if (r_win == WIN_W'(1)) w_state_nxt = DONE;
      end
      DONE: begin
        w_capture   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    silly_edge_lane #(.CNT_W(CNT_W)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_sig     (sig_in[g]),
      .i_clear   (w_clear),
      .i_enable  (w_enable),
      .i_capture (w_capture),
      .o_res     (w_res[g]),
      .o_res_ovf (w_res_ovf[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_res[lane_sel];
      r_ovf   <= w_res_ovf[lane_sel];
    end
  end

  assign busy  = (r_state != IDLE);
  assign done  = (r_state == DONE);
  assign count = r_count;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_silly_edge_meter.sv
// Directed/random bench for silly_edge_meter at CNT_W=16 and CNT_W=4.
module tb_silly_edge_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sig_in;
  logic        start;
  logic [11:0] win_len;
  logic [2:0]  lane_sel;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [15:0] count_a;
  logic [3:0]  count_b;

  always #5 clk = ~clk;

  silly_edge_meter #(.CNT_W(16), .WIN_W(12)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .win_len(win_len),
    .lane_sel(lane_sel), .busy(busy_a), .done(done_a), .count(count_a), .ovf(ovf_a));

  silly_edge_meter #(.CNT_W(4), .WIN_W(12)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .win_len(win_len),
    .lane_sel(lane_sel), .busy(busy_b), .done(done_b), .count(count_b), .ovf(ovf_b));

  int         n_chk  = 0;
  int         n_pass = 0;
  int         cyc    = 0;
  logic [7:0] hist[$];
  int         exp_res [2][8];
  bit         exp_ovf [2][8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: lane0 clk/2; mode 1: lane1 clk/4, lane2 clk/8, lane3 stuck 1; else random
  function automatic logic [7:0] gen(input int m, input int c);
    logic [7:0] s;
    s = 8'($urandom);
    if (m == 0) s[0] = c[0];
    else if (m == 1) begin
      s[1] = c[1];
      s[2] = c[2];
      s[3] = 1'b1;
    end
    return s;
  endfunction

  function automatic int edges(input int l);
    int e = 0;
    for (int j = 1; j < hist.size(); j++)
      if (hist[j][l] && !hist[j-1][l]) e++;
    return e;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < 8; l++) begin
        exp_res[d][l] = 0;
        exp_ovf[d][l] = 1'b0;
      end
  endtask

  // One full measurement; poke pulses start mid-window to show it is ignored.
  task automatic run(input int wl, input int m, input bit poke);
    int e;
    int sel;
    hist.delete();
    start   = 1'b1;
    win_len = 12'(wl);
    sig_in  = gen(m, cyc);
    hist.push_back(sig_in);
    tick();
    start = 1'b0;
    for (int k = 1; k <= wl; k++) begin
      chk("busy_meas", busy_a, 1);
      chk("done_early", done_a, 0);
      sig_in = gen(m, cyc);
      hist.push_back(sig_in);
      if (poke && k == 3) begin
        start   = 1'b1;
        win_len = 12'd5;
      end else start = 1'b0;
      tick();
    end
    start = 1'b0;
    chk("done_a", done_a, 1);
    chk("done_b", done_b, 1);
    chk("busy_done", busy_a, 1);
    for (int l = 0; l < 8; l++) begin
      e = edges(l);
      exp_res[0][l] = (e > 65535) ? 65535 : e;
      exp_ovf[0][l] = (e > 65535);
      exp_res[1][l] = (e > 15) ? 15 : e;
      exp_ovf[1][l] = (e > 15);
    end
    sel      = $urandom_range(0, 7);
    lane_sel = 3'(sel);
    sig_in   = gen(2, cyc);
    tick();
    chk("done_after", done_a, 0);
    chk("busy_after", busy_a, 0);
    chk("cnt_a_post", count_a, exp_res[0][sel]);
    chk("ovf_a_post", ovf_a, exp_ovf[0][sel]);
    chk("cnt_b_post", count_b, exp_res[1][sel]);
    chk("ovf_b_post", ovf_b, exp_ovf[1][sel]);
  endtask

  task automatic sweep();
    for (int s = 0; s < 8; s++) begin
      lane_sel = 3'(s);
      sig_in   = gen(2, cyc);
      tick();
      chk("sweep_cnt_a", count_a, exp_res[0][s]);
      chk("sweep_ovf_a", ovf_a, exp_ovf[0][s]);
      chk("sweep_cnt_b", count_b, exp_res[1][s]);
      chk("sweep_ovf_b", ovf_b, exp_ovf[1][s]);
    end
  endtask

  task automatic show(input int s);
    lane_sel = 3'(s);
    tick();
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    win_len  = '0;
    sig_in   = '0;
    lane_sel = '0;
    model_clear();
    tick();
    tick();
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_cnt_a", count_a, 0);
    chk("rst_ovf_a", ovf_a, 0);
    chk("rst_cnt_b", count_b, 0);
    rst_n = 1'b1;
    tick();

    // clk/2 on lane 0, 16-cycle window
    run(16, 0, 1'b0);
    show(0);
    chk("clk2_cnt", count_a, 8);
    chk("clk2_ovf", ovf_a, 0);
    chk("clk2_cnt_b", count_b, 8);

    // divider pattern on lanes 1..3, 64-cycle window
    run(64, 1, 1'b0);
    show(1);
    chk("clk4_cnt", count_a, 16);
    chk("clk4_cnt_b", count_b, 15);
    chk("clk4_ovf_b", ovf_b, 1);
    show(2);
    chk("clk8_cnt", count_a, 8);
    show(3);
    chk("const_cnt", count_a, 0);

    // saturation on the narrow instance, then cleared by the next start
    run(64, 0, 1'b0);
    show(0);
    chk("sat_cnt_b", count_b, 15);
    chk("sat_ovf_b", ovf_b, 1);
    chk("sat_cnt_a", count_a, 32);
    run(8, 0, 1'b0);
    show(0);
    chk("unsat_cnt_b", count_b, 4);
    chk("unsat_ovf_b", ovf_b, 0);

    // zero-length window
    run(0, 2, 1'b0);
    sweep();

    // start pulsed mid-window is ignored
    run(20, 2, 1'b1);
    sweep();

    // results persist while idle
    for (int i = 0; i < 10; i++) begin
      sig_in = gen(2, cyc);
      tick();
    end
    sweep();

    // random back-to-back windows
    for (int r = 0; r < 6; r++) begin
      run($urandom_range(1, 40), 2, 1'b0);
      if (r % 2 == 1) sweep();
    end

    // reset in the middle of a window
    start   = 1'b1;
    win_len = 12'd20;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sig_in = gen(2, cyc);
      tick();
    end
    rst_n = 1'b0;
    tick();
    model_clear();
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_cnt_a", count_a, 0);
    chk("mid_rst_cnt_b", count_b, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      sig_in = gen(2, cyc);
      tick();
      chk("no_done_a", done_a, 0);
      chk("no_done_b", done_b, 0);
    end
    sweep();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
